// File: rtl/serial_subtractor_nbit.sv
// Bit-serial unsigned subtractor: diff = a - b, one bit per clock, LSB first,
// built from a single full-subtractor cell and a registered borrow.
module serial_subtractor_nbit #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         borrow
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_r;
  logic [N-1:0]  a_sr_r;
  logic [N-1:0]  b_sr_r;
  logic [N-1:0]  r_sr_r;
  logic          br_r;
  logic [CW-1:0] cnt_r;

  logic          d_s;
  logic          bout_s;
  logic          accept_s;
  logic [N-1:0]  r_next_s;

  function automatic logic fs_diff(input logic x, input logic y, input logic bin);
    return x ^ y ^ bin;
  endfunction

  function automatic logic fs_borrow(input logic x, input logic y, input logic bin);
    return (~x & y) | (~(x ^ y) & bin);
  endfunction

  // Full-subtractor cell on the current LSBs plus the next result-register value.
  always_comb begin
    d_s      = fs_diff(a_sr_r[0], b_sr_r[0], br_r);
    bout_s   = fs_borrow(a_sr_r[0], b_sr_r[0], br_r);
    r_next_s = {d_s, r_sr_r[N-1:1]};
  end

  // A request is only honoured outside RUN.
  always_comb begin
    accept_s = 1'b0;
    case (state_r)
      IDLE:    accept_s = start;
      DONE:    accept_s = start;
      RUN:     accept_s = 1'b0;
      default: accept_s = 1'b0;
    endcase
  end

  // Sequencer, datapath shift registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      a_sr_r  <= {N{1'b0}};
      b_sr_r  <= {N{1'b0}};
      r_sr_r  <= {N{1'b0}};
      br_r    <= 1'b0;
      cnt_r   <= {CW{1'b0}};
      busy    <= 1'b0;
      done    <= 1'b0;
      diff    <= {N{1'b0}};
      borrow  <= 1'b0;
    end else if (accept_s) begin
      state_r <= RUN;
      a_sr_r  <= a;
      b_sr_r  <= b;
      r_sr_r  <= {N{1'b0}};
      br_r    <= 1'b0;
      cnt_r   <= {CW{1'b0}};
      busy    <= 1'b1;
      done    <= 1'b0;
    end else begin
      case (state_r)
        RUN: begin
          a_sr_r <= {1'b0, a_sr_r[N-1:1]};
          b_sr_r <= {1'b0, b_sr_r[N-1:1]};
          r_sr_r <= r_next_s;
          br_r   <= bout_s;
          // The counter stops at N-1 so it never wraps inside an operation.
          if (cnt_r == LAST_CNT) begin
            state_r <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            diff    <= r_next_s;
            borrow  <= bout_s;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
        IDLE: begin
          busy <= 1'b0;
          done <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_nbit.sv
// Scoreboard bench for serial_subtractor_nbit: directed N=4 vectors plus an
// N=8 random regression checked against (a-b) mod 256 and a<b.
module tb_serial_subtractor_nbit;

  logic       clk;
  logic       rst_n;
  logic       start4, start8;
  logic [3:0] a4, b4;
  logic [7:0] a8, b8;
  logic       busy4, done4, borrow4;
  logic       busy8, done8, borrow8;
  logic [3:0] diff4;
  logic [7:0] diff8;

  int checks = 0;
  int errors = 0;

  logic [8:0] q4[$];
  logic [8:0] q8[$];
  logic [8:0] last_res[2];
  int         run_len[2];

  serial_subtractor_nbit #(.N(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4)
  );

  serial_subtractor_nbit #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle monitor: values are {borrow, diff zero-extended to 8 bits}.
  task automatic mon(input int id, input int n, input logic rn, input logic bsy,
                     input logic dn, input logic [7:0] df, input logic br);
    logic [8:0] exp;
    logic       have;
    exp  = 9'd0;
    have = 1'b0;
    if (!rn) begin
      chk($sformatf("rst_outputs%0d", id), {br, df}, 9'd0);
      chk($sformatf("rst_flags%0d", id), {7'd0, bsy, dn}, 9'd0);
      last_res[id] = 9'd0;
      run_len[id]  = 0;
    end else begin
      if (bsy && dn) begin
        checks++;
        errors++;
        $display("FAIL busy_and_done%0d: both high at %0t", id, $time);
      end
      if (dn) begin
        if (id == 0 && q4.size() > 0) begin
          exp  = q4.pop_front();
          have = 1'b1;
        end else if (id == 1 && q8.size() > 0) begin
          exp  = q8.pop_front();
          have = 1'b1;
        end
        if (have) begin
          chk($sformatf("result%0d", id), {br, df}, exp);
          chk($sformatf("busy_cycles%0d", id), 9'(run_len[id]), 9'(n));
        end else begin
          checks++;
          errors++;
          $display("FAIL unexpected_done%0d: got 0x%0h with no expected entry at %0t",
                   id, {br, df}, $time);
        end
        last_res[id] = exp;
        run_len[id]  = 0;
      end else begin
        chk($sformatf("hold%0d", id), {br, df}, last_res[id]);
        if (bsy) run_len[id]++;
      end
    end
  endtask

  always @(negedge clk) mon(0, 4, rst_n, busy4, done4, {4'd0, diff4}, borrow4);
  always @(negedge clk) mon(1, 8, rst_n, busy8, done8, diff8, borrow8);

  // Single N=4 operation with a one-cycle start pulse, then settle in IDLE.
  task automatic op4(input logic [3:0] av, input logic [3:0] bv, input logic [4:0] res);
    @(posedge clk); #1;
    start4 = 1'b1; a4 = av; b4 = bv;
    q4.push_back({res[4], 4'd0, res[3:0]});
    @(posedge clk); #1;
    start4 = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  initial begin
    logic [7:0] ra, rb;
    int         gap;
    rst_n = 1'b0; start4 = 1'b0; start8 = 1'b0;
    a4 = 4'd0; b4 = 4'd0; a8 = 8'd0; b8 = 8'd0;
    last_res[0] = 9'd0; last_res[1] = 9'd0;
    run_len[0] = 0; run_len[1] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state4", {busy4, done4, borrow4, 2'd0, diff4}, 9'd0);
    rst_n = 1'b1;

    // Directed vectors: {borrow, diff}
    op4(4'd9,  4'd3,  {1'b0, 4'd6});
    op4(4'd3,  4'd9,  {1'b1, 4'd10});
    op4(4'd0,  4'd1,  {1'b1, 4'd15});
    op4(4'd15, 4'd15, {1'b0, 4'd0});

    // start held high, new operands presented in the DONE cycle
    @(posedge clk); #1;
    start4 = 1'b1; a4 = 4'd12; b4 = 4'd5;
    q4.push_back({1'b0, 4'd0, 4'd7});
    repeat (5) @(posedge clk);
    #1;
    a4 = 4'd5; b4 = 4'd12;
    q4.push_back({1'b1, 4'd0, 4'd9});
    @(posedge clk); #1;
    start4 = 1'b0;
    repeat (6) @(posedge clk);

    // start and operands disturbed mid-RUN must be ignored
    @(posedge clk); #1;
    start4 = 1'b1; a4 = 4'd6; b4 = 4'd2;
    q4.push_back({1'b0, 4'd0, 4'd4});
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk); #1;
    start4 = 1'b1; a4 = 4'd15; b4 = 4'd0;
    @(posedge clk); #1;
    start4 = 1'b0; a4 = 4'd1; b4 = 4'd14;
    repeat (6) @(posedge clk);

    // asynchronous reset in the middle of a run: no result expected
    @(posedge clk); #1;
    start4 = 1'b1; a4 = 4'd13; b4 = 4'd4;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset4", {busy4, done4, borrow4, 2'd0, diff4}, 9'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    op4(4'd8, 4'd8, {1'b0, 4'd0});

    // N=8 regression with random gaps, gap 0 means back-to-back
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      start8 = 1'b1; a8 = ra; b8 = rb;
      q8.push_back({(ra < rb) ? 1'b1 : 1'b0, 8'(ra - rb)});
      @(posedge clk); #1;
      start8 = 1'b0;
      a8 = 8'($urandom_range(0, 255));
      b8 = 8'($urandom_range(0, 255));
      repeat (8) @(posedge clk);
      #1;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
      end
    end
    repeat (12) @(posedge clk);
    #1;

    chk("queue_empty4", 9'(q4.size()), 9'd0);
    chk("queue_empty8", 9'(q8.size()), 9'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
